// File: rtl/sequential_borrow_subtractor_32bits_if.sv
// Operand/result handshake bundle for the multi-cycle borrow subtractor.
// The master side drives the operands and consumes the result; the slave side is the subtractor.
interface sequential_borrow_subtractor_32bits_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             Ovf;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, D, Bout, Ovf
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, D, Bout, Ovf
  );
endinterface

// File: rtl/sequential_borrow_subtractor_32bits.sv
// Multi-cycle ripple-borrow subtractor: D = A - B - Bin, CHUNK bits per clock,
// with a registered borrow between chunks and valid/ready handshakes on both sides.
module sequential_borrow_subtractor_32bits #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                             clk,
  input logic                             rst_n,
  sequential_borrow_subtractor_32bits_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CHUNK:0]   diff;
  logic [WIDTH-1:0] d_merged;
  logic             last;
  int               sh;

  // Operand registers shift right each RUN cycle, so the active chunk is always
  // in the low CHUNK bits; on the last cycle their top bits are the original sign bits.
  // NOTE: every variable assigned in always_comb gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    diff     = {1'b0, a_q[CHUNK-1:0]} - {1'b0, b_q[CHUNK-1:0]} - (CHUNK+1)'(borrow_q);
    sh       = int'(idx_q) * CHUNK;
    d_merged = (d_q & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(diff[CHUNK-1:0]) << sh);
    last     = (idx_q == IW'(N - 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.A;
            b_q        <= bus.B;
            borrow_q   <= bus.Bin;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          d_q      <= d_merged;
          borrow_q <= diff[CHUNK];
          a_q      <= a_q >> CHUNK;
          b_q      <= b_q >> CHUNK;
          idx_q    <= idx_q + IW'(1);
          if (last) begin
            bout_q      <= diff[CHUNK];
            ovf_q       <= (a_q[CHUNK-1] != b_q[CHUNK-1]) && (diff[CHUNK-1] != a_q[CHUNK-1]);
            out_valid_q <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.D         = d_q;
  assign bus.Bout      = bout_q;
  assign bus.Ovf       = ovf_q;
endmodule

// File: tb/tb_sequential_borrow_subtractor_32bits.sv
// Self-checking bench: directed vectors and corner sequences on a CHUNK=8 instance,
// plus randomized back-to-back traffic with stalls on CHUNK=1, 8 and 32 instances.
module tb_sequential_borrow_subtractor_32bits;
  logic clk = 1'b0;
  logic rst_n;
  logic rst_rn;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rand_done = 0;

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bin;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: unsigned difference gives D and the borrow, exact signed difference gives overflow.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic bin);
    logic [32:0]        u;
    logic signed [33:0] s;
    logic               ovf;
    u   = {1'b0, a} - {1'b0, b} - 33'(bin);
    s   = 34'($signed(a)) - 34'($signed(b)) - $signed({33'd0, bin});
    ovf = (s > 34'sd2147483647) || (s < -34'sd2147483648);
    return {ovf, u[32], u[31:0]};
  endfunction

  sequential_borrow_subtractor_32bits_if #(.WIDTH(32)) bus8 ();
  sequential_borrow_subtractor_32bits #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  for (genvar g = 0; g < 3; g++) begin : g_rand
    localparam int CH = (g == 0) ? 1 : ((g == 1) ? 8 : 32);
    logic [33:0] exp_q[$];

    sequential_borrow_subtractor_32bits_if #(.WIDTH(32)) rb ();
    sequential_borrow_subtractor_32bits #(.WIDTH(32), .CHUNK(CH)) dut (
      .clk  (clk),
      .rst_n(rst_rn),
      .bus  (rb)
    );

    initial begin
      int wt;
      rb.in_valid = 1'b0;
      rb.A = '0;
      rb.B = '0;
      rb.Bin = 1'b0;
      @(posedge rst_rn);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if ($urandom_range(7) == 0) begin
          rb.in_valid = 1'b0;
          @(negedge clk);
        end
        rb.A   = $urandom;
        rb.B   = (i % 50 == 0) ? 32'hFFFF_FFFF : $urandom;
        rb.Bin = 1'($urandom_range(1));
        rb.in_valid = 1'b1;
        wt = 0;
        while (!rb.in_ready && wt < 300) begin
          @(negedge clk);
          wt++;
        end
        if (wt >= 300) begin
          check($sformatf("rand_c%0d_accept_timeout", CH), 64'(wt), 64'(0));
          break;
        end
        exp_q.push_back(model(rb.A, rb.B, rb.Bin));
        @(posedge clk);
      end
      @(negedge clk);
      rb.in_valid = 1'b0;
    end

    initial begin
      int got;
      int cyc;
      logic [33:0] e;
      got = 0;
      cyc = 0;
      rb.out_ready = 1'b0;
      @(posedge rst_rn);
      while (got < 1000 && cyc < 80000) begin
        @(negedge clk);
        cyc++;
        rb.out_ready = ($urandom_range(3) != 0);
        if (rb.out_valid && rb.out_ready) begin
          check($sformatf("rand_c%0d_queue_nonempty", CH), 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check($sformatf("rand_c%0d_op%0d", CH, got), {30'd0, rb.Ovf, rb.Bout, rb.D}, {30'd0, e});
          end
          got++;
        end
      end
      check($sformatf("rand_c%0d_count", CH), 64'(got), 64'(1000));
      rand_done++;
    end
  end

  task automatic run_op(input vec_t v, input string nm);
    int wt;
    int edges;
    @(negedge clk);
    bus8.A = v.a;
    bus8.B = v.b;
    bus8.Bin = v.bin;
    bus8.in_valid = 1'b1;
    wt = 0;
    while (!bus8.in_ready && wt < 100) begin
      @(negedge clk);
      wt++;
    end
    check({nm, "_accept"}, 64'(wt < 100), 64'(1));
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus8.out_valid && edges < 50);
    check({nm, "_latency"}, 64'(edges), 64'(4));
    check({nm, "_result"}, {61'd0, bus8.Ovf, bus8.Bout, 1'b0} | {bus8.D, 32'd0},
          {61'd0, v.ovf, v.bout, 1'b0} | {v.d, 32'd0});
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({nm, "_release"}, {62'd0, bus8.out_valid, bus8.in_ready}, 64'b01);
    bus8.out_ready = 1'b0;
  endtask

  task automatic wait_out_valid(input string nm);
    int edges;
    edges = 0;
    while (!bus8.out_valid && edges < 50) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({nm, "_out_valid"}, 64'(bus8.out_valid), 64'(1));
  endtask

  initial begin
    vec_t vecs[8];
    int   cyc;
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0000, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[6] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    rst_rn = 1'b0;
    bus8.in_valid = 1'b0;
    bus8.A = '0;
    bus8.B = '0;
    bus8.Bin = 1'b0;
    bus8.out_ready = 1'b0;
    #1;
    check("reset_outputs", {bus8.in_ready, bus8.out_valid, bus8.Bout, bus8.Ovf, bus8.D}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rst_rn = 1'b1;
    @(negedge clk);
    check("in_ready_after_reset", 64'(bus8.in_ready), 64'(1));

    for (int i = 0; i < 8; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Result held through a long output stall while a second operand waits.
    @(negedge clk);
    bus8.A = 32'd100;
    bus8.B = 32'd1;
    bus8.Bin = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.A = 32'h10;
    bus8.B = 32'h20;
    bus8.Bin = 1'b1;
    wait_out_valid("stall_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall_hold%0d", i),
            {bus8.in_ready, bus8.out_valid, bus8.Ovf, bus8.Bout, bus8.D},
            {1'b0, 1'b1, 1'b0, 1'b0, 32'd99});
    end
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;
    check("stall_to_idle", {bus8.out_valid, bus8.in_ready, bus8.D}, {1'b0, 1'b1, 32'd99});
    @(posedge clk);
    #1;
    bus8.in_valid = 1'b0;
    check("stall_second_accepted", 64'(bus8.in_ready), 64'(0));
    wait_out_valid("stall_second");
    check("stall_second_result", {bus8.Ovf, bus8.Bout, bus8.D}, {1'b0, 1'b1, 32'hFFFF_FFEF});
    @(negedge clk);
    bus8.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.out_ready = 1'b0;

    // Asynchronous reset in the middle of RUN abandons the operation.
    @(negedge clk);
    bus8.A = 32'h1234_5678;
    bus8.B = 32'h0101_0101;
    bus8.Bin = 1'b0;
    bus8.in_valid = 1'b1;
    @(posedge clk);
    #1 bus8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_immediate", {bus8.in_ready, bus8.out_valid, bus8.Bout, bus8.Ovf, bus8.D}, 64'd0);
    repeat (2) @(negedge clk);
    check("midrun_reset_held", {bus8.in_ready, bus8.out_valid, bus8.Bout, bus8.Ovf, bus8.D}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrun_in_ready_after", 64'(bus8.in_ready), 64'(1));
    run_op('{32'd10, 32'd3, 1'b1, 32'd6, 1'b0, 1'b0}, "after_reset");

    cyc = 0;
    while (rand_done < 3 && cyc < 90000) begin
      @(negedge clk);
      cyc++;
    end
    check("random_runners_done", 64'(rand_done), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
